// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared state encoding, strobe width and word-alignment helpers
// for the data-memory responder and its lane-mask helper.
package mem_access_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int          STRB_W    = 4;
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] word_addr(input logic [31:0] a);
        return a & WORD_MASK;
    endfunction

endpackage

// File: rtl/mem_lane_mask.sv
// mem_lane_mask: zeroes every byte lane of a 32-bit word whose strobe bit is clear.
module mem_lane_mask
    import mem_access_pkg::*;
(
    input  logic [31:0]       i_data,
    input  logic [STRB_W-1:0] i_strb,
    output logic [31:0]       o_data
);

    for (genvar i = 0; i < STRB_W; i++) begin : g_lane
        assign o_data[8*i +: 8] = i_strb[i] ? i_data[8*i +: 8] : 8'h00;
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: load/store responder that runs the store phase, then the load phase,
// on a req/ack data bus, stalling the pipeline until the access completes.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    output logic              o_stall,
    input  logic              i_a_valid,
    input  logic [31:0]       i_a_load_addr,
    input  logic [STRB_W-1:0] i_a_load_strb,
    input  logic [31:0]       i_a_store_addr,
    input  logic [STRB_W-1:0] i_a_store_strb,
    input  logic [31:0]       i_a_store_data,
    output logic [31:0]       o_m_load_data,
    output logic [STRB_W-1:0] o_m_load_strb,
    output logic              o_m_err,
    output logic              o_wr_req,
    output logic [31:0]       o_wr_addr,
    output logic [STRB_W-1:0] o_wr_strb,
    output logic [31:0]       o_wr_data,
    input  logic              i_wr_ack,
    output logic              o_rd_req,
    output logic [31:0]       o_rd_addr,
    input  logic              i_rd_ack,
    input  logic [31:0]       i_rd_data
);

    localparam logic [7:0] TO = 8'(TIMEOUT);

    state_t            r_state, w_next;
    logic [31:0]       r_ld_addr, r_st_addr, r_st_data, r_ld_data;
    logic [STRB_W-1:0] r_ld_strb, r_st_strb, r_m_strb;
    logic [7:0]        r_cnt;
    logic              r_err;
    logic              w_accept, w_phase, w_ack, w_timeout;
    logic [31:0]       w_masked;

    mem_lane_mask u_mask (
        .i_data (i_rd_data),
        .i_strb (r_ld_strb),
        .o_data (w_masked)
    );

    assign w_accept  = r_state == ST_IDLE && i_a_valid && !i_flush
                       && (|i_a_store_strb || |i_a_load_strb);
    assign w_phase   = r_state == ST_WRITE || r_state == ST_READ;
    assign w_ack     = (r_state == ST_WRITE && i_wr_ack) || (r_state == ST_READ && i_rd_ack);
    assign w_timeout = w_phase && !w_ack && r_cnt == TO;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  w_next = !w_accept ? ST_IDLE : (|i_a_store_strb ? ST_WRITE : ST_READ);
            ST_WRITE: w_next = w_ack ? (|r_ld_strb ? ST_READ : ST_DONE) : (w_timeout ? ST_DONE : ST_WRITE);
            ST_READ:  w_next = (w_ack || w_timeout) ? ST_DONE : ST_READ;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ld_addr <= '0;
            r_st_addr <= '0;
            r_st_data <= '0;
            r_ld_strb <= '0;
            r_st_strb <= '0;
            r_ld_data <= '0;
            r_m_strb  <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_timeout;
            r_cnt <= (w_phase && w_next == r_state) ? r_cnt + 8'd1 : 8'd0;
            if (w_accept) begin
                r_ld_addr <= i_a_load_addr;
                r_st_addr <= i_a_store_addr;
                r_st_data <= i_a_store_data;
                r_ld_strb <= i_a_load_strb;
                r_st_strb <= i_a_store_strb;
            end
            // Result is cleared while idle so a timed-out access reports zeros.
            if (r_state == ST_IDLE) begin
                r_ld_data <= '0;
                r_m_strb  <= '0;
            end else if (r_state == ST_READ && i_rd_ack) begin
                r_ld_data <= w_masked;
                r_m_strb  <= r_ld_strb;
            end
        end
    end

    assign o_stall       = i_rst_n && (w_accept || w_phase);
    assign o_wr_req      = r_state == ST_WRITE;
    assign o_rd_req      = r_state == ST_READ;
    assign o_wr_addr     = word_addr(r_st_addr);
    assign o_wr_strb     = r_st_strb;
    assign o_wr_data     = r_st_data;
    assign o_rd_addr     = word_addr(r_ld_addr);
    assign o_m_load_data = r_ld_data;
    assign o_m_load_strb = r_m_strb;
    assign o_m_err       = r_err;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized load/store transactions against a transaction-level
// model of stall length, phase lengths, error and masked load result.
module tb_mem_access;
    localparam int T = 4;

    logic        i_clk = 1'b0, i_rst_n = 1'b0, i_flush = 1'b0, i_a_valid = 1'b0;
    logic [31:0] i_a_load_addr = '0, i_a_store_addr = '0, i_a_store_data = '0, i_rd_data = '0;
    logic [3:0]  i_a_load_strb = '0, i_a_store_strb = '0;
    logic        i_wr_ack = 1'b0, i_rd_ack = 1'b0;
    logic        o_stall, o_m_err, o_wr_req, o_rd_req;
    logic [31:0] o_m_load_data, o_wr_addr, o_wr_data, o_rd_addr;
    logic [3:0]  o_m_load_strb, o_wr_strb;

    int n_checks = 0, n_fail = 0;

    mem_access #(.TIMEOUT(T)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .o_stall(o_stall),
        .i_a_valid(i_a_valid), .i_a_load_addr(i_a_load_addr), .i_a_load_strb(i_a_load_strb),
        .i_a_store_addr(i_a_store_addr), .i_a_store_strb(i_a_store_strb),
        .i_a_store_data(i_a_store_data), .o_m_load_data(o_m_load_data),
        .o_m_load_strb(o_m_load_strb), .o_m_err(o_m_err), .o_wr_req(o_wr_req),
        .o_wr_addr(o_wr_addr), .o_wr_strb(o_wr_strb), .o_wr_data(o_wr_data),
        .i_wr_ack(i_wr_ack), .o_rd_req(o_rd_req), .o_rd_addr(o_rd_addr),
        .i_rd_ack(i_rd_ack), .i_rd_data(i_rd_data)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++) if (!s[b]) d[8*b +: 8] = 8'h00;
        return d;
    endfunction

    // Starts on a negedge with the block idle; leaves it idle with no request.
    task automatic run_txn(input logic [3:0] ss, input logic [3:0] ls, input logic [31:0] sa,
                           input logic [31:0] la, input logic [31:0] sd, input logic [31:0] rdata,
                           input int dw, input int dr);
        int wc = 0, rc = 0, n = 0, ewc, erc;
        logic both = 1'b0, wbad = 1'b0, rbad = 1'b0, wto, rd_en, rto;
        wto   = ss != 0 && dw > T;
        ewc   = ss != 0 ? (wto ? T + 1 : dw + 1) : 0;
        rd_en = ls != 0 && !wto;
        rto   = rd_en && dr > T;
        erc   = rd_en ? (rto ? T + 1 : dr + 1) : 0;
        i_a_valid = 1'b1; i_flush = 1'b0;
        i_a_store_strb = ss; i_a_load_strb = ls;
        i_a_store_addr = sa; i_a_load_addr = la; i_a_store_data = sd;
        #1 chk("accept_stall", 32'(o_stall), 32'd1);
        @(negedge i_clk);
        while (o_stall && n < 40) begin
            if (o_wr_req) begin
                if (o_wr_addr !== {sa[31:2], 2'b00} || o_wr_strb !== ss || o_wr_data !== sd) wbad = 1'b1;
                i_wr_ack = wc == dw;
                wc++;
            end else i_wr_ack = 1'($urandom);
            if (o_rd_req) begin
                if (o_rd_addr !== {la[31:2], 2'b00}) rbad = 1'b1;
                i_rd_ack  = rc == dr;
                i_rd_data = rc == dr ? rdata : $urandom;
                rc++;
            end else begin
                i_rd_ack  = 1'($urandom);
                i_rd_data = $urandom;
            end
            if (o_wr_req && o_rd_req) both = 1'b1;
            i_flush = 1'($urandom);
            n++;
            @(negedge i_clk);
        end
        chk("bound", 32'(n < 40), 32'd1);
        chk("stall_cycles", 32'(n), 32'(ewc + erc));
        chk("wr_cycles", 32'(wc), 32'(ewc));
        chk("rd_cycles", 32'(rc), 32'(erc));
        chk("wr_fields", 32'(wbad), 32'd0);
        chk("rd_addr", 32'(rbad), 32'd0);
        chk("req_overlap", 32'(both), 32'd0);
        chk("done_err", 32'(o_m_err), 32'(wto || rto));
        chk("done_data", o_m_load_data, (rd_en && !rto) ? lanes(rdata, ls) : 32'h0);
        chk("done_strb", 32'(o_m_load_strb), (rd_en && !rto) ? 32'(ls) : 32'h0);
        i_a_valid = 1'b0; i_flush = 1'b0; i_wr_ack = 1'b0; i_rd_ack = 1'b0;
        @(negedge i_clk);
        chk("idle_err", 32'(o_m_err), 32'd0);
        chk("idle_stall", 32'(o_stall), 32'd0);
        @(negedge i_clk);
        chk("idle_clear", {28'h0, o_m_load_strb} | o_m_load_data, 32'h0);
    endtask

    initial begin
        logic [3:0] ss, ls;
        #2;
        chk("rst_stall", 32'(o_stall), 32'd0);
        chk("rst_reqs", {30'h0, o_wr_req, o_rd_req}, 32'h0);
        chk("rst_outs", o_wr_addr | o_wr_data | o_rd_addr | o_m_load_data | {27'h0, o_m_err, o_wr_strb | o_m_load_strb}, 32'h0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        run_txn(4'hF, 4'h0, 32'h0000_1006, 32'h0, 32'hDEAD_BEEF, 32'h0, 2, 0);
        run_txn(4'h0, 4'b0100, 32'h0, 32'h0000_2001, 32'h0, 32'h1122_3344, 0, 0);
        run_txn(4'b0011, 4'b1100, 32'h0000_3000, 32'h0000_3002, 32'h0000_5566, 32'hAABB_CCDD, 1, 2);
        run_txn(4'h0, 4'hF, 32'h0, 32'h0000_4000, 32'h0, 32'h1234_5678, 0, 10);
        run_txn(4'hF, 4'hF, 32'h0000_5000, 32'h0000_6000, 32'h0BAD_F00D, 32'h7777_7777, 9, 0);

        // Flush in idle blocks acceptance; an empty request is not accepted either.
        i_a_valid = 1'b1; i_flush = 1'b1; i_a_load_strb = 4'h3; i_a_store_strb = 4'h0;
        #1 chk("flush_stall", 32'(o_stall), 32'd0);
        @(negedge i_clk);
        chk("flush_noreq", {30'h0, o_rd_req, o_stall}, 32'h0);
        i_flush = 1'b0; i_a_load_strb = 4'h0;
        #1 chk("empty_stall", 32'(o_stall), 32'd0);
        i_a_valid = 1'b0;
        @(negedge i_clk);

        // Asynchronous reset mid-write.
        i_a_valid = 1'b1; i_a_store_strb = 4'hF; i_a_load_strb = 4'hF;
        i_a_store_addr = 32'h0000_7000; i_wr_ack = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        chk("pre_rst_wr", 32'(o_wr_req), 32'd1);
        #2 i_rst_n = 1'b0;
        #1 chk("rst_wr_drop", 32'(o_wr_req), 32'd0);
        chk("rst_stall_drop", 32'(o_stall), 32'd0);
        i_a_valid = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("rst_no_err", 32'(o_m_err), 32'd0);
        run_txn(4'h0, 4'b0010, 32'h0, 32'h0000_8000, 32'h0, 32'hCAFE_BABE, 1, 1);

        for (int k = 0; k < 40; k++) begin
            ss = ($urandom % 3 == 0) ? 4'h0 : 4'($urandom);
            ls = ($urandom % 3 == 0) ? 4'h0 : 4'($urandom);
            if (ss == 0 && ls == 0) ls = 4'h1;
            run_txn(ss, ls, $urandom, $urandom, $urandom, $urandom,
                    int'($urandom_range(0, 6)), int'($urandom_range(0, 6)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Data-memory responder for the RV32I pipeline.
- Accepts load/store requests from the ALU stage and executes them on the data bus with request/acknowledge handshakes.
- Holds the pipeline with STALL until the access completes, then presents masked load data to the memory-read stage.
- Sits between the ALU stage outputs and the data bus (BRAM/AXI bridge).

Parameters:
- TIMEOUT, 255: bus cycles to wait for an ACK before abandoning the access; the counter is 8 bits wide.

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-low (all state clears when RST=0)
- FLUSH  in  1  pipeline flush; suppresses acceptance of a new request
- STALL  out  1  hold the pipeline
- A_VALID  in  1  ALU-stage instruction valid
- A_LOAD_ADDR  in  32  load byte address
- A_LOAD_STRB  in  4  load byte lanes; 0 means no load
- A_STORE_ADDR  in  32  store byte address
- A_STORE_STRB  in  4  store byte lanes; 0 means no store
- A_STORE_DATA  in  32  store data, already lane-aligned
- M_LOAD_DATA  out  32  load word, non-strobed lanes zeroed
- M_LOAD_STRB  out  4  lanes of the completed load
- M_ERR  out  1  one-cycle pulse on timeout
- WR_REQ  out  1  bus write request
- WR_ADDR  out  32  word address {addr[31:2],2'b00}
- WR_STRB  out  4  write byte enables
- WR_DATA  out  32  write data
- WR_ACK  in  1  write accepted
- RD_REQ  out  1  bus read request
- RD_ADDR  out  32  word address {addr[31:2],2'b00}
- RD_ACK  in  1  read data valid on RD_DATA
- RD_DATA  in  32  read data

Behaviour:
- States: IDLE, WRITE, READ, DONE. Reset puts the block in IDLE.
- Reset values: every output is 0, and latched addr/strb/data and the timeout counter are 0.
- Request accept: in IDLE, a request is presented when A_VALID=1, FLUSH=0 and (A_STORE_STRB≠0 or A_LOAD_STRB≠0).
- On accept:
  - STALL is driven high combinationally in that same cycle.
  - All A_* fields are latched.
  - Next state is WRITE if the store strobe is non-zero, otherwise READ.
- No request in IDLE: STALL=0, stay in IDLE, and M_LOAD_DATA/M_LOAD_STRB are cleared to 0.
- WRITE:
  - WR_REQ=1 with WR_ADDR/WR_STRB/WR_DATA held stable until WR_ACK is sampled high.
  - On ACK: go to READ if a load is latched, else DONE. Store always precedes load when both are present.
- READ:
  - RD_REQ=1 with RD_ADDR held stable until RD_ACK.
  - On ACK, M_LOAD_DATA is registered as RD_DATA with each byte lane i zeroed where strb[i]=0. No shifting or sign extension; those belong to a later stage.
  - M_LOAD_STRB is registered from the latched load strobe. Next state is DONE.
- ACK while REQ is low is ignored. An ACK in the same cycle REQ first rises completes the phase, so each phase takes at least 1 cycle.
- DONE: STALL=0 for exactly one cycle, M_LOAD_* hold the result, then return to IDLE. DONE never accepts a request, because the A_* inputs still belong to the completed instruction.
- Latency: a single load or store with a same-cycle ACK takes accept + 1 phase cycle + DONE, i.e. STALL high for 2 cycles. A store+load takes 3.
- Timeout:
  - The counter resets to 0 on entering each of WRITE and READ and increments every cycle without ACK.
  - When it reaches TIMEOUT, the request is dropped and the block goes to DONE.
  - M_ERR pulses in that DONE cycle; M_LOAD_DATA=0 and M_LOAD_STRB=0.
  - A timed-out store skips any pending load.
- FLUSH while in WRITE/READ is ignored; the bus transaction must complete or time out. FLUSH only blocks acceptance in IDLE.
- Asynchronous reset mid-transaction: REQ drops immediately and there is no completion pulse.

Decomposition:
- Shared package/header holds:
  - State encodings ST_IDLE=2'd0, ST_WRITE=2'd1, ST_READ=2'd2, ST_DONE=2'd3.
  - The word-align mask.
  - Strobe width constant 4.
- One natural sub-module: mem_lane_mask, a combinational byte-lane zeroing of 32-bit data by a 4-bit strobe. It is reusable by the memory-read stage.

Test Plan:
- Store SW addr 0x0000_1006, strb 4'b1111, data 0xDEADBEEF, WR_ACK after 2 cycles:
  - WR_ADDR=0x0000_1004 held for 3 cycles.
  - STALL high 4 cycles, then low 1 cycle (DONE).
  - M_LOAD_STRB=0.
- Load LB lane 2, strb 4'b0100, RD_DATA=0x11223344, same-cycle ACK:
  - M_LOAD_DATA=0x00220000, M_LOAD_STRB=4'b0100.
  - STALL pattern 1,1,0.
- Both strobes non-zero:
  - WR_REQ completes before RD_REQ rises.
  - RD_REQ and WR_REQ are never high together.
- No ACK, TIMEOUT=4:
  - RD_REQ high for 5 cycles then drops.
  - M_ERR=1 for one cycle, M_LOAD_DATA=0.
- FLUSH=1 with A_VALID=1 and load strobe in IDLE: no RD_REQ and STALL=0. FLUSH during READ: the read still completes.
- RST=0 asserted mid-WRITE (async, between clock edges): WR_REQ and STALL fall immediately; after release the block is in IDLE and a new request is accepted.
